menu_screen_renderer: RTL and testbench
=======================================

Name: menu_screen_renderer

Overview:
- Parametrised full-screen menu renderer for the VGA pipeline, sitting between the VGA controller (DrawX/DrawY/blank) and the RGB output pins.
- Upscales a background sprite from an external synchronous ROM by a power-of-two factor and resolves colour through an external palette.
- Overlays a blinking outline on the selected menu item and runs a frame-timed fade-in, select and fade-out sequence.
- Reports the chosen item to the game FSM.

Parameters:
- SRC_W, 320, source sprite width in pixels.
- SRC_H, 240, source sprite height in pixels.
- SCALE_SHIFT, 1, screen-to-source scale as log2 (source coordinate = screen coordinate >> SCALE_SHIFT).
- IDX_W, 3, palette index width.
- NUM_ITEMS, 2, number of menu items (>=2).
- ITEM_X, 224, left edge (screen x) of every item box.
- ITEM_Y0, 288, top edge (screen y) of item 0.
- ITEM_PITCH, 48, vertical distance between item tops.
- ITEM_W, 192, item box width.
- ITEM_H, 32, item box height.
- HL_COLOR, 12'hFF0, outline colour as {r,g,b}.
- BLINK_FRAMES, 16, frames per blink half-period.
- FADE_STEP_FRAMES, 4, frames per fade intensity step.
- Derived, not overridable: ADDR_W = $clog2(SRC_W*SRC_H); SEL_W = $clog2(NUM_ITEMS).

Ports:
- vga_clk  in  1  pixel clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel x.
- DrawY  in  10  current pixel y.
- blank  in  1  1 = visible pixel (display enable).
- btn_up  in  1  one-cycle pulse, move selection up.
- btn_down  in  1  one-cycle pulse, move selection down.
- btn_select  in  1  one-cycle pulse, confirm the current item.
- menu_start  in  1  one-cycle pulse, restart the menu from DONE.
- rom_address  out  ADDR_W  sprite ROM address, registered.
- rom_q  in  IDX_W  ROM data; valid 1 cycle after rom_address.
- pal_index  out  IDX_W  equals rom_q, fed to the palette.
- pal_red, pal_green, pal_blue  in  4 each  palette colour, combinational from pal_index.
- red, green, blue  out  4 each  final pixel colour, registered.
- menu_done  out  1  level; high in DONE.
- menu_choice  out  SEL_W  item confirmed by the last select.

Behaviour:
- Reset (async, reset_n low):
  - red/green/blue = 0, rom_address = 0, menu_done = 0, menu_choice = 0.
  - sel = 0, state = FADE_IN, intensity = 0.
  - frame_cnt = 0, blink_cnt = 0, blink_on = 1.
  - All pipeline registers cleared.
- Pipeline, fixed latency 3 cycles from DrawX/DrawY/blank to red/green/blue:
  - S0 (posedge 1): rom_address <= (DrawX>>SCALE_SHIFT) + (DrawY>>SCALE_SHIFT)*SRC_W. Shifts and constant multiply only, no divider. Source x/y are clamped to SRC_W-1/SRC_H-1.
  - Also in S0, register blank plus an outline hit flag.
  - Outline hit = pixel inside the box of item sel AND within 2 px of any box edge.
  - Box of item i: x in [ITEM_X, ITEM_X+ITEM_W), y in [ITEM_Y0+i*ITEM_PITCH, ... +ITEM_H).
  - S1: ROM returns rom_q; pipe blank and hit one more stage.
  - S2: colour = (hit && blink_on && state==ACTIVE) ? HL_COLOR : pal.
  - Each channel out = sat_sub(channel, 15-intensity), floored at 0.
  - Output 0 when the piped blank = 0 or state = DONE.
- Frame tick: asserted for one cycle when DrawX==0 && DrawY==0 at the input.
- FSM states: FADE_IN, ACTIVE, FADE_OUT, DONE.
  - FADE_IN: on each tick frame_cnt++. When frame_cnt==FADE_STEP_FRAMES-1, frame_cnt=0 and intensity++. When intensity reaches 15, go to ACTIVE (same cycle as that step). Buttons are ignored.
  - ACTIVE: btn_down increments sel, NUM_ITEMS-1 wraps to 0. btn_up decrements sel, 0 wraps to NUM_ITEMS-1. sel updates the next cycle.
  - ACTIVE: btn_up and btn_down in the same cycle means no change.
  - ACTIVE: btn_select latches menu_choice=sel and goes to FADE_OUT, frame_cnt=0. Select beats up/down in the same cycle; the pre-move sel is used.
  - ACTIVE blink: blink_cnt counts ticks. At BLINK_FRAMES-1 it clears and blink_on toggles. Entering ACTIVE or any sel change sets blink_cnt=0 and blink_on=1.
  - FADE_OUT: intensity-- per FADE_STEP_FRAMES ticks. When it reaches 0, go to DONE. Buttons are ignored.
  - DONE: menu_done=1 and outputs are black. menu_start goes to FADE_IN with intensity=0, sel=0, frame_cnt=0; menu_done falls the next cycle. menu_choice holds until the next select.
  - menu_start outside DONE is ignored.
- Reset asserted mid-fade or mid-frame returns immediately to the reset state. The pipeline flush yields black for 3 cycles after release.

Test Plan:
- Address and latency (SCALE_SHIFT=1):
  - Force state ACTIVE/intensity 15 via the fade sequence, then drive DrawX=639, DrawY=479, blank=1 -> rom_address=76799 one cycle later.
  - Drive rom_q=5 with pal=4'hA,4'h3,4'h1 -> red/green/blue=A,3,1 exactly 3 cycles after the input.
  - DrawX=1, DrawY=1 -> rom_address=0.
- Fade in:
  - From reset, issue 60 frame ticks -> intensity steps every 4 ticks; a pal value of F reads 0,1,...,F.
  - Reaches ACTIVE on tick 60; buttons before that do not change sel.
- Navigation (NUM_ITEMS=2, ACTIVE):
  - btn_down -> sel=1; btn_down -> sel=0 (wrap); btn_up -> sel=1 (wrap).
  - Up and down together -> unchanged.
  - Outline pixel at (ITEM_X, ITEM_Y0+48) outputs FF0 when sel=1.
  - After 16 ticks the outline is off, after 32 ticks on again.
- Select and done:
  - sel=1, btn_select together with btn_down -> menu_choice=1 and state FADE_OUT.
  - After 60 ticks -> menu_done=1, outputs 0.
  - menu_start -> menu_done=0 next cycle, sel=0, fade-in restarts.
- Blank:
  - blank=0 with ROM/palette nonzero in ACTIVE -> red/green/blue=0 exactly 3 cycles later, with no effect on adjacent pixels.
- Reset mid-operation:
  - reset_n low during FADE_OUT at intensity 7 -> outputs 0 asynchronously, state FADE_IN, intensity 0, menu_choice 0.

Source files
------------

// File: rtl/menu_screen_renderer.sv
// ---------------------------------------------------------------------------
// menu_screen_renderer
//
// Full-screen menu renderer placed between the VGA controller and the RGB
// pins. A background sprite held in an external synchronous ROM is upscaled
// by 2**SCALE_SHIFT. Its colour is resolved through an external palette. A
// blinking outline marks the selected item. A frame-timed fade-in / select /
// fade-out sequence drives the overall intensity.
//
// Ports
//   vga_clk, reset_n        pixel clock, async active-low reset
//   DrawX, DrawY, blank     current pixel and display enable (1 = visible)
//   btn_up/down/select      one-cycle button pulses
//   menu_start              one-cycle pulse, restarts the menu from DONE
//   rom_address / rom_q     sprite ROM port (rom_q valid 1 cycle after address)
//   pal_index / pal_*       palette lookup (combinational colour return)
//   red, green, blue        registered pixel colour, 3 cycles after DrawX/Y
//   menu_done, menu_choice  handshake to the game FSM
// ---------------------------------------------------------------------------
module menu_screen_renderer #(
  parameter int          SRC_W            = 320,
  parameter int          SRC_H            = 240,
  parameter int          SCALE_SHIFT      = 1,
  parameter int          IDX_W            = 3,
  parameter int          NUM_ITEMS        = 2,
  parameter int          ITEM_X           = 224,
  parameter int          ITEM_Y0          = 288,
  parameter int          ITEM_PITCH       = 48,
  parameter int          ITEM_W           = 192,
  parameter int          ITEM_H           = 32,
  parameter logic [11:0] HL_COLOR         = 12'hFF0,
  parameter int          BLINK_FRAMES     = 16,
  parameter int          FADE_STEP_FRAMES = 4,
  localparam int         ADDR_W           = $clog2(SRC_W*SRC_H),
  localparam int         SEL_W            = $clog2(NUM_ITEMS)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_select,
  input  logic              menu_start,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              menu_done,
  output logic [SEL_W-1:0]  menu_choice
);

  localparam int FC_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {FADE_IN, ACTIVE, FADE_OUT, DONE} state_t;

  state_t           state, state_n;
  logic [3:0]       intensity, intensity_n;
  logic [FC_W-1:0]  frame_cnt, frame_cnt_n;
  logic [BC_W-1:0]  blink_cnt, blink_cnt_n;
  logic             blink_on, blink_on_n;
  logic [SEL_W-1:0] sel, sel_n;
  logic [SEL_W-1:0] choice_n;

  logic frame_tick;
  assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'd0);

  // ---------------- S0: address generation and outline hit ----------------
  logic [9:0]        src_x_raw, src_y_raw, src_x, src_y;
  logic [ADDR_W-1:0] addr_next;
  logic [11:0]       px, py, box_top;
  logic              in_box, near_edge, hit;

  always_comb begin
    src_x_raw = DrawX >> SCALE_SHIFT;
    src_y_raw = DrawY >> SCALE_SHIFT;
    src_x     = (src_x_raw > 10'(SRC_W-1)) ? 10'(SRC_W-1) : src_x_raw;
    src_y     = (src_y_raw > 10'(SRC_H-1)) ? 10'(SRC_H-1) : src_y_raw;
    // Constant multiply by the sprite width; no divider in the path.
    addr_next = ADDR_W'(src_y) * ADDR_W'(SRC_W) + ADDR_W'(src_x);

    px        = {2'b00, DrawX};
    py        = {2'b00, DrawY};
    box_top   = 12'(ITEM_Y0) + 12'(sel) * 12'(ITEM_PITCH);
    in_box    = (px >= 12'(ITEM_X)) && (px < 12'(ITEM_X + ITEM_W)) &&
                (py >= box_top)     && (py < box_top + 12'(ITEM_H));
    // Two-pixel-thick outline band on the inside of the box.
    near_edge = (px <  12'(ITEM_X + 2)) || (px >= 12'(ITEM_X + ITEM_W - 2)) ||
                (py <  box_top + 12'd2)  || (py >= box_top + 12'(ITEM_H - 2));
    hit       = in_box && near_edge;
  end

  logic blank_s0, hit_s0, blank_s1, hit_s1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; combinational blocks use blocking ones.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      blank_s0    <= 1'b0;
      hit_s0      <= 1'b0;
      blank_s1    <= 1'b0;
      hit_s1      <= 1'b0;
    end else begin
      rom_address <= addr_next;
      blank_s0    <= blank;
      hit_s0      <= hit;
      blank_s1    <= blank_s0;
      hit_s1      <= hit_s0;
    end
  end

  assign pal_index = rom_q;

  // ---------------- S2: colour select, fade, output register ---------------
  function automatic logic [3:0] sat_sub(input logic [3:0] c, input logic [3:0] d);
    return (c > d) ? (c - d) : 4'd0;
  endfunction

  logic [11:0] src_rgb;
  logic [3:0]  dim;
  logic        show_hl;

  always_comb begin
    show_hl = hit_s1 && blink_on && (state == ACTIVE);
    src_rgb = show_hl ? HL_COLOR : {pal_red, pal_green, pal_blue};
    dim     = 4'd15 - intensity;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end else if (!blank_s1 || state == DONE) begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end else begin
      red   <= sat_sub(src_rgb[11:8], dim);
      green <= sat_sub(src_rgb[7:4],  dim);
      blue  <= sat_sub(src_rgb[3:0],  dim);
    end
  end

  // ---------------- Menu FSM ----------------
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FADE_IN;
      intensity   <= 4'd0;
      frame_cnt   <= '0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      sel         <= '0;
      menu_choice <= '0;
    end else begin
      state       <= state_n;
      intensity   <= intensity_n;
      frame_cnt   <= frame_cnt_n;
      blink_cnt   <= blink_cnt_n;
      blink_on    <= blink_on_n;
      sel         <= sel_n;
      menu_choice <= choice_n;
    end
  end

  // NOTE: every output of this block is given its hold value first, so no
  // path through the case statement can leave one unassigned (no latches).
  always_comb begin
    state_n     = state;
    intensity_n = intensity;
    frame_cnt_n = frame_cnt;
    blink_cnt_n = blink_cnt;
    blink_on_n  = blink_on;
    sel_n       = sel;
    choice_n    = menu_choice;

    unique case (state)
      FADE_IN: begin
        if (frame_tick) begin
          if (frame_cnt == FC_W'(FADE_STEP_FRAMES - 1)) begin
            frame_cnt_n = '0;
            intensity_n = intensity + 4'd1;
            if (intensity == 4'd14) begin
              state_n     = ACTIVE;
              blink_cnt_n = '0;
              blink_on_n  = 1'b1;
            end
          end else begin
            frame_cnt_n = frame_cnt + FC_W'(1);
          end
        end
      end

      ACTIVE: begin
        if (btn_select) begin
          // Select wins over a simultaneous move and keeps the pre-move item.
          choice_n    = sel;
          state_n     = FADE_OUT;
          frame_cnt_n = '0;
        end else if (btn_up ^ btn_down) begin
          if (btn_down)
            sel_n = (sel == SEL_W'(NUM_ITEMS - 1)) ? '0 : sel + SEL_W'(1);
          else
            sel_n = (sel == '0) ? SEL_W'(NUM_ITEMS - 1) : sel - SEL_W'(1);
          // Restart the blink so the newly selected outline shows at once.
          blink_cnt_n = '0;
          blink_on_n  = 1'b1;
        end else if (frame_tick) begin
          if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_n = '0;
            blink_on_n  = ~blink_on;
          end else begin
            blink_cnt_n = blink_cnt + BC_W'(1);
          end
        end
      end

      FADE_OUT: begin
        if (frame_tick) begin
          if (frame_cnt == FC_W'(FADE_STEP_FRAMES - 1)) begin
            frame_cnt_n = '0;
            intensity_n = intensity - 4'd1;
            if (intensity == 4'd1) state_n = DONE;
          end else begin
            frame_cnt_n = frame_cnt + FC_W'(1);
          end
        end
      end

      DONE: begin
        if (menu_start) begin
          state_n     = FADE_IN;
          intensity_n = 4'd0;
          sel_n       = '0;
          frame_cnt_n = '0;
        end
      end

      default: state_n = FADE_IN;
    endcase
  end

  assign menu_done = (state == DONE);

endmodule

// File: tb/tb_menu_screen_renderer.sv
// ---------------------------------------------------------------------------
// tb_menu_screen_renderer
//
// Directed bench for menu_screen_renderer with default parameters. The bench
// models the sprite ROM (index = low 3 address bits) and an 8-entry palette.
// Stimulus pushes the hand-computed expected pixel colour and ROM address into
// queues; a monitor pops and compares them when the tagged pixel reaches the
// output (1 cycle for the address, 3 cycles for the colour).
// ---------------------------------------------------------------------------
module tb_menu_screen_renderer;

  logic        vga_clk;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic        btn_up, btn_down, btn_select, menu_start;
  logic [16:0] rom_address;
  logic [2:0]  rom_q;
  logic [2:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic        menu_done;
  logic [0:0]  menu_choice;

  menu_screen_renderer dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_select  (btn_select),
    .menu_start  (menu_start),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pal_index   (pal_index),
    .pal_red     (pal_red),
    .pal_green   (pal_green),
    .pal_blue    (pal_blue),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .menu_done   (menu_done),
    .menu_choice (menu_choice)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Sprite ROM: synchronous, index is the low three address bits.
  initial rom_q = '0;
  always @(posedge vga_clk) rom_q <= rom_address[2:0];

  function automatic logic [11:0] pal_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    return 12'h000;
      3'd1:    return 12'hFFF;
      3'd2:    return 12'h123;
      3'd3:    return 12'h888;
      3'd4:    return 12'h0F0;
      3'd5:    return 12'hA31;
      3'd6:    return 12'h456;
      default: return 12'hFFF;
    endcase
  endfunction

  assign {pal_red, pal_green, pal_blue} = pal_lut(pal_index);

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [11:0] rgb;
    int          id;
  } px_exp_t;

  px_exp_t     px_q[$];
  logic [16:0] addr_q[$];
  int          px_id = 0;
  int          n_checks = 0;
  int          n_fails = 0;

  logic       px_tag = 1'b0;
  logic       a_tag  = 1'b0;
  logic [2:0] px_d   = '0;
  logic       a_d    = 1'b0;

  always @(posedge vga_clk) begin
    px_d <= {px_d[1:0], px_tag};
    a_d  <= a_tag;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge vga_clk) begin
    if (px_d[2]) begin
      if (px_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL px_underflow: output tagged with no expected value queued");
      end else begin
        px_exp_t e;
        e = px_q.pop_front();
        check($sformatf("px%0d", e.id), {20'd0, red, green, blue}, {20'd0, e.rgb});
      end
    end
    if (a_d) begin
      if (addr_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL addr_underflow: address tagged with no expected value queued");
      end else begin
        logic [16:0] ea;
        ea = addr_q.pop_front();
        check("rom_address", {15'd0, rom_address}, {15'd0, ea});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    DrawX = 10'd5; DrawY = 10'd5; blank = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0; menu_start = 1'b0;
    px_tag = 1'b0; a_tag = 1'b0;
  endtask

  // Present the current inputs for one clock edge, then return to idle.
  task automatic cyc();
    @(posedge vga_clk);
    #1;
    idle_inputs();
  endtask

  task automatic flush();
    repeat (3) cyc();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
      cyc();
    end
  endtask

  task automatic pix(input int x, input int y, input logic b, input logic [11:0] rgb);
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    px_q.push_back(px_exp_t'{rgb: rgb, id: px_id});
    px_id++;
    px_tag = 1'b1;
    cyc();
  endtask

  task automatic pix_a(input int x, input int y, input logic b, input logic [11:0] rgb,
                       input logic [16:0] addr);
    addr_q.push_back(addr);
    a_tag = 1'b1;
    pix(x, y, b, rgb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge vga_clk);
    #1;
    check("rst_rgb",    {20'd0, red, green, blue}, 32'h0);
    check("rst_addr",   {15'd0, rom_address}, 32'h0);
    check("rst_done",   {31'd0, menu_done}, 32'h0);
    check("rst_choice", {31'd0, menu_choice}, 32'h0);
    reset_n = 1'b1;
    cyc();

    // Fade in: white pixel reads 0..14; buttons must be ignored meanwhile.
    for (int k = 0; k < 15; k++) begin
      pix(2, 0, 1'b1, {4'(k), 4'(k), 4'(k)});
      flush();
      if (k == 5) begin btn_down = 1'b1; cyc(); end
      if (k == 9) begin btn_up = 1'b1; btn_select = 1'b1; cyc(); end
      ticks(4);
    end
    pix(2, 0, 1'b1, 12'hFFF);

    // Addressing, clamping and the ROM -> palette path.
    pix_a(639, 479, 1'b1, 12'hFFF, 17'd76799);
    pix_a(1, 1, 1'b1, 12'h000, 17'd0);
    pix_a(10, 2, 1'b1, 12'hA31, 17'd325);
    pix_a(1023, 600, 1'b1, 12'hFFF, 17'd76799);

    // Blank in the middle of a run of identical pixels.
    pix(10, 2, 1'b1, 12'hA31);
    pix(10, 2, 1'b0, 12'h000);
    pix(10, 2, 1'b1, 12'hA31);
    flush();

    // Outline of item 0 (sel still 0): edges, interior and outside.
    pix(224, 288, 1'b1, 12'hFF0);
    pix(224, 336, 1'b1, 12'h000);
    pix(240, 300, 1'b1, 12'h000);
    pix(225, 300, 1'b1, 12'hFF0);
    pix(226, 300, 1'b1, 12'hFFF);
    pix(415, 300, 1'b1, 12'hFF0);
    pix(416, 300, 1'b1, 12'h000);
    pix(300, 319, 1'b1, 12'hFF0);
    pix(300, 320, 1'b1, 12'h456);
    flush();

    // Navigation with wrap in both directions.
    btn_down = 1'b1; cyc();
    pix(224, 336, 1'b1, 12'hFF0);
    pix(224, 288, 1'b1, 12'h000);
    flush();
    btn_down = 1'b1; cyc();
    pix(224, 288, 1'b1, 12'hFF0);
    pix(224, 336, 1'b1, 12'h000);
    flush();
    btn_up = 1'b1; cyc();
    pix(224, 336, 1'b1, 12'hFF0);
    flush();
    btn_up = 1'b1; btn_down = 1'b1; cyc();
    pix(224, 336, 1'b1, 12'hFF0);
    pix(224, 288, 1'b1, 12'h000);
    flush();

    // Blink: on for 16 ticks, off for 16 ticks.
    ticks(15); pix(224, 336, 1'b1, 12'hFF0); flush();
    ticks(1);  pix(224, 336, 1'b1, 12'h000); flush();
    ticks(15); pix(224, 336, 1'b1, 12'h000); flush();
    ticks(1);  pix(224, 336, 1'b1, 12'hFF0); flush();

    // Select together with down: the pre-move item is reported.
    btn_select = 1'b1; btn_down = 1'b1; cyc();
    check("choice_sel1", {31'd0, menu_choice}, 32'd1);
    check("done_fadeout", {31'd0, menu_done}, 32'd0);
    pix(224, 336, 1'b1, 12'h000);
    pix(2, 0, 1'b1, 12'hFFF);
    flush();

    // Fade out; a stray menu_start must not disturb it.
    for (int k = 0; k < 15; k++) begin
      pix(2, 0, 1'b1, {4'(15 - k), 4'(15 - k), 4'(15 - k)});
      flush();
      if (k == 3) begin menu_start = 1'b1; cyc(); end
      if (k == 14) check("done_before_last", {31'd0, menu_done}, 32'd0);
      ticks(4);
    end
    check("done_high", {31'd0, menu_done}, 32'd1);
    pix(2, 0, 1'b1, 12'h000);
    pix(10, 2, 1'b1, 12'h000);
    flush();

    // Restart from DONE.
    menu_start = 1'b1; cyc();
    check("done_fall", {31'd0, menu_done}, 32'd0);
    check("choice_hold", {31'd0, menu_choice}, 32'd1);
    pix(2, 0, 1'b1, 12'h000);
    flush();
    ticks(4);
    pix(2, 0, 1'b1, 12'h111);
    flush();
    ticks(56);
    pix(224, 288, 1'b1, 12'hFF0);
    pix(2, 0, 1'b1, 12'hFFF);
    flush();

    // Select item 0, fade out to intensity 7, then reset mid-fade.
    btn_select = 1'b1; cyc();
    check("choice_sel0", {31'd0, menu_choice}, 32'd0);
    ticks(32);
    pix(2, 0, 1'b1, 12'h777);
    flush();

    DrawX = 10'd2; DrawY = 10'd0; blank = 1'b1;
    repeat (4) @(posedge vga_clk);
    #1;
    check("pre_reset_red", {28'd0, red}, 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rgb",    {20'd0, red, green, blue}, 32'h0);
    check("async_addr",   {15'd0, rom_address}, 32'h0);
    check("async_choice", {31'd0, menu_choice}, 32'h0);
    check("async_done",   {31'd0, menu_done}, 32'h0);
    @(posedge vga_clk);
    @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge vga_clk);
      #1;
      check($sformatf("flush_rgb%0d", i), {20'd0, red, green, blue}, 32'h0);
    end
    idle_inputs();
    cyc();
    pix(2, 0, 1'b1, 12'h000);
    flush();
    ticks(4);
    pix(2, 0, 1'b1, 12'h111);
    flush();

    check("sb_px_empty",   px_q.size(), 32'd0);
    check("sb_addr_empty", addr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
